booth_controller: RTL and testbench
===================================

BOOTH_CONTROLLER -- requirements
Module: booth_controller

Interface
REQ-001 Parameter DATA_WIDTH SHALL default to 16: operand width; the iteration count the datapath counter is initialized to on clearCounter.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request a multiply; it is sampled only in IDLE.
REQ-005 op_valid  input  1  SHALL indicate that the operand on the datapath data_in bus is valid in LDM/LDQ.
REQ-006 abort  input  1  SHALL be a synchronous cancel of the current operation.
REQ-007 eqz, q0, qm1  input  1 each  SHALL be the counter-zero flag, the Q0 bit and the Q-1 bit from the datapath.
REQ-008 loadA, clearA, shiftA, loadQ, clearQ, shiftQ, loadM, clearM, clearff, addSub, clearCounter, decr, count_en  output  1 each  SHALL drive the datapath controls of the same names.
REQ-009 op_req  output  1  SHALL be high in LDM and LDQ to request an operand on data_in.
REQ-010 busy  output  1  SHALL be high in every state except IDLE.
REQ-011 done  output  1  SHALL pulse for exactly one cycle when the product is valid in AregOut:QregOut.

Function
REQ-012 The states SHALL be IDLE, INIT, LDM, LDQ, CHECK, ARITH, SHIFT and DONE.
REQ-013 All outputs SHALL be decoded from the registered state only, except loadM and loadQ, which are each ANDed with op_valid.
REQ-014 IDLE: start=1 SHALL go to INIT next cycle; otherwise the block stays in IDLE with all controls at 0.
REQ-015 INIT: clearA, clearQ, clearM, clearff and clearCounter SHALL be 1 for one cycle; the next state SHALL be LDM.
REQ-016 LDM: loadM SHALL equal op_valid; the block stays in LDM until op_valid=1, then goes to LDQ (multiplicand captured from data_in).
REQ-017 LDQ: loadQ SHALL equal op_valid; the block stays in LDQ until op_valid=1, then goes to CHECK (multiplier captured).
REQ-018 CHECK transitions:
- eqz=1: go to DONE; eqz has priority over the Booth decode.
- else {q0,qm1}=2'b01: go to ARITH with addSub=0 (A+M).
- else {q0,qm1}=2'b10: go to ARITH with addSub=1 (A-M).
- else (00/11): go to SHIFT.
REQ-019 The add/subtract direction SHALL be held in a 1-bit register captured in CHECK.
REQ-020 ARITH: loadA=1 and addSub SHALL equal the registered direction for one cycle; the next state SHALL be SHIFT.
REQ-021 SHIFT: shiftA, shiftQ, decr and count_en SHALL be 1 for one cycle (arithmetic right shift of A:Q:Q-1 and counter decrement); the next state SHALL be CHECK.
REQ-022 DONE: done=1 for one cycle; the next state SHALL be IDLE.
REQ-023 Latency from start to done SHALL be 4 + DATA_WIDTH*2 + (number of add/sub iterations) + 1 cycles, plus any op_valid wait cycles.
REQ-024 start asserted while busy=1 SHALL be ignored (no queueing).
REQ-025 abort=1 in any non-IDLE state SHALL go to IDLE next cycle without a done pulse, and clearA/clearQ/clearff/clearCounter SHALL be 1 in that abort cycle.
REQ-026 abort SHALL have priority over all other transitions; abort in IDLE SHALL have no effect.
REQ-027 op_valid outside LDM/LDQ SHALL be ignored.

Reset
REQ-028 On rst_n=0 the state SHALL be IDLE, the direction register 0, and every output 0, asynchronously; the block leaves reset on the first rising edge after rst_n=1.
REQ-029 Reset asserted mid-operation SHALL drop busy and all controls immediately, with no done pulse.

Configuration
REQ-030 Macro BOOTH_CYCLE_CNT_EN: when defined, an output cycle_cnt [7:0] SHALL count busy cycles of the current operation, clear in INIT, saturate at 255 and hold after DONE until the next INIT.
REQ-031 When BOOTH_CYCLE_CNT_EN is undefined, the port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 start, M=3, Q=5, op_valid=1 -> 3*5: done after 4+32+adds+1 cycles, product 15, one done pulse.
REQ-033 Q=16'h0000 -> no ARITH entries (loadA never 1), done at cycle 37, product 0.
REQ-034 M=16'hFFFF (-1), Q=16'h0002 -> exactly two ARITH cycles (subtract then add), product 32'hFFFF_FFFE.
REQ-035 op_valid held low for 3 cycles in LDM -> loadM stays 0, the block stays in LDM, latency +3.
REQ-036 abort during SHIFT -> IDLE next cycle, clears pulsed, no done; a following start produces a correct product.
REQ-037 start while busy, and rst_n low mid-ARITH -> start ignored; on reset all outputs 0 asynchronously; with BOOTH_CYCLE_CNT_EN, cycle_cnt equals the measured latency at done.

Source files
------------

// File: rtl/booth_controller.sv
// Control FSM for a radix-2 Booth multiplier datapath (A:Q:Q-1 shifter, M register, iteration counter).
// Define BOOTH_CYCLE_CNT_EN to add the cycle_cnt[7:0] busy-cycle counter output.
module booth_controller #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       op_valid,
  input  logic       abort,
  input  logic       eqz,
  input  logic       q0,
  input  logic       qm1,
  output logic       loadA,
  output logic       clearA,
  output logic       shiftA,
  output logic       loadQ,
  output logic       clearQ,
  output logic       shiftQ,
  output logic       loadM,
  output logic       clearM,
  output logic       clearff,
  output logic       addSub,
  output logic       clearCounter,
  output logic       decr,
  output logic       count_en,
  output logic       op_req,
  output logic       busy,
  output logic       done
`ifdef BOOTH_CYCLE_CNT_EN
  ,
  output logic [7:0] cycle_cnt
`endif
);

  localparam int unsigned StateW = 3;
  localparam int unsigned CntW   = 8;

  typedef enum logic [StateW-1:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    LDM   = 3'd2,
    LDQ   = 3'd3,
    CHECK = 3'd4,
    ARITH = 3'd5,
    SHIFT = 3'd6,
    DONE  = 3'd7
  } state_e;

  // The datapath counter is reloaded with DATA_WIDTH; zero iterations would make no sense.
  if (DATA_WIDTH < 1) begin : g_width_check
    $error("booth_controller: DATA_WIDTH must be at least 1");
  end

  state_e state_q, state_d;
  logic   dir_q, dir_d;
  logic   aborting_c;

`ifdef BOOTH_CYCLE_CNT_EN
  logic [CntW-1:0] cnt_q, cnt_d;
  assign cycle_cnt = cnt_q;
`endif

  assign aborting_c = abort && (state_q != IDLE);

  // State and direction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
`ifdef BOOTH_CYCLE_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
`ifdef BOOTH_CYCLE_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state logic; abort outranks every other transition once busy
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    if (aborting_c) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (start) state_d = INIT;
        INIT:  state_d = LDM;
        LDM:   if (op_valid) state_d = LDQ;
        LDQ:   if (op_valid) state_d = CHECK;
        CHECK: begin
          if (eqz) begin
            state_d = DONE;
          end else if (q0 ^ qm1) begin
            state_d = ARITH;
            dir_d   = q0;  // 10 -> subtract, 01 -> add
          end else begin
            state_d = SHIFT;
          end
        end
        ARITH: state_d = SHIFT;
        SHIFT: state_d = CHECK;
        DONE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

`ifdef BOOTH_CYCLE_CNT_EN
    // Loading 1 on entry to INIT makes the value seen in DONE equal the start-to-done latency
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (start) cnt_d = CntW'(1);
    end else if (state_q != DONE) begin
      cnt_d = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);
    end
`endif
  end

  // Output decode from registered state; only the operand loads look at op_valid
  always_comb begin
    loadA        = 1'b0;
    clearA       = 1'b0;
    shiftA       = 1'b0;
    loadQ        = 1'b0;
    clearQ       = 1'b0;
    shiftQ       = 1'b0;
    loadM        = 1'b0;
    clearM       = 1'b0;
    clearff      = 1'b0;
    addSub       = 1'b0;
    clearCounter = 1'b0;
    decr         = 1'b0;
    count_en     = 1'b0;
    op_req       = 1'b0;
    busy         = (state_q != IDLE);
    done         = 1'b0;
    if (aborting_c) begin
      clearA       = 1'b1;
      clearQ       = 1'b1;
      clearff      = 1'b1;
      clearCounter = 1'b1;
    end else begin
      case (state_q)
        INIT: begin
          clearA       = 1'b1;
          clearQ       = 1'b1;
          clearM       = 1'b1;
          clearff      = 1'b1;
          clearCounter = 1'b1;
        end
        LDM: begin
          op_req = 1'b1;
          loadM  = op_valid;
        end
        LDQ: begin
          op_req = 1'b1;
          loadQ  = op_valid;
        end
        ARITH: begin
          loadA  = 1'b1;
          addSub = dir_q;
        end
        SHIFT: begin
          shiftA   = 1'b1;
          shiftQ   = 1'b1;
          decr     = 1'b1;
          count_en = 1'b1;
        end
        DONE:    done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_controller.sv
// Scoreboard bench for booth_controller driving a behavioural Booth datapath model.
module tb_booth_controller;

  logic clk, rst_n, start, op_valid, abort;
  logic eqz, q0, qm1;
  logic loadA, clearA, shiftA, loadQ, clearQ, shiftQ, loadM, clearM, clearff;
  logic addSub, clearCounter, decr, count_en, op_req, busy, done;
`ifdef BOOTH_CYCLE_CNT_EN
  logic [7:0] cycle_cnt;
`endif

  logic [15:0] data_in, areg, qreg, mreg;
  logic        qm1_r;
  logic [5:0]  cnt_r;
  logic [15:0] outs;

  typedef struct {
    logic [31:0] prod;
    int          lat;
    int          adds;
    int          seq;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0, t0 = 0, adds_cnt = 0, seq = 0;

  booth_controller #(.DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_valid(op_valid), .abort(abort),
    .eqz(eqz), .q0(q0), .qm1(qm1),
    .loadA(loadA), .clearA(clearA), .shiftA(shiftA), .loadQ(loadQ), .clearQ(clearQ),
    .shiftQ(shiftQ), .loadM(loadM), .clearM(clearM), .clearff(clearff), .addSub(addSub),
    .clearCounter(clearCounter), .decr(decr), .count_en(count_en), .op_req(op_req),
    .busy(busy), .done(done)
`ifdef BOOTH_CYCLE_CNT_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  assign outs = {loadA, clearA, shiftA, loadQ, clearQ, shiftQ, loadM, clearM,
                 clearff, addSub, clearCounter, decr, count_en, op_req, busy, done};

  // Behavioural datapath: A:Q:Q-1 with arithmetic right shift, M register, iteration counter
  assign eqz = (cnt_r == 6'd0);
  assign q0  = qreg[0];
  assign qm1 = qm1_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      areg <= '0; qreg <= '0; mreg <= '0; qm1_r <= 1'b0; cnt_r <= '0;
    end else begin
      if (clearA) areg <= '0;
      else if (loadA) areg <= addSub ? areg - mreg : areg + mreg;
      else if (shiftA) areg <= {areg[15], areg[15:1]};
      if (clearQ) qreg <= '0;
      else if (loadQ) qreg <= data_in;
      else if (shiftQ) qreg <= {areg[0], qreg[15:1]};
      if (clearff) qm1_r <= 1'b0;
      else if (shiftQ) qm1_r <= qreg[0];
      if (clearM) mreg <= '0;
      else if (loadM) mreg <= data_in;
      if (clearCounter) cnt_r <= 6'd16;
      else if (decr && count_en) cnt_r <= cnt_r - 6'd1;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops an expectation for every done pulse and compares product, latency and Booth op sequence
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (start && !busy && rst_n) begin
        t0 = cyc; adds_cnt = 0; seq = 0;
      end
      if (loadA) begin
        adds_cnt++;
        seq = (seq << 1) | int'(addSub);
      end
      if (done) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, required 0 (nothing pending)", cyc);
        end else begin
          e = sb.pop_front();
          chk("product", 64'({areg, qreg}), 64'(e.prod));
          chk("latency", 64'(cyc - t0), 64'(e.lat));
          chk("arith_count", 64'(adds_cnt), 64'(e.adds));
          chk("arith_sequence", 64'(seq), 64'(e.seq));
`ifdef BOOTH_CYCLE_CNT_EN
          chk("cycle_cnt", 64'(cycle_cnt), 64'(e.lat));
`endif
        end
      end
    end
  endtask

  task automatic run_op(input logic [15:0] m, input logic [15:0] q, input int mwait,
                        input bit keep_valid, input bit busy_start, input logic [31:0] exp_prod,
                        input int exp_lat, input int exp_adds, input int exp_seq);
    exp_t e;
    int   n;
    e.prod = exp_prod; e.lat = exp_lat; e.adds = exp_adds; e.seq = exp_seq;
    sb.push_back(e);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("init_decode", 64'(outs), 64'(16'h49A2));
    step();
    for (int i = 0; i < mwait; i++) begin
      chk("ldm_wait_loadM", 64'(loadM), 64'(0));
      chk("ldm_wait_op_req", 64'(op_req), 64'(1));
      step();
    end
    data_in = m; op_valid = 1'b1;
    #1;
    chk("ldm_loadM", 64'(loadM), 64'(1));
    step();
    data_in = q;
    #1;
    chk("ldq_loadQ", 64'(loadQ), 64'(1));
    step();
    op_valid = keep_valid;
    data_in  = 16'hA5A5;
    if (busy_start) begin
      for (int i = 0; i < 3; i++) begin
        start = 1'b1;
        #1;
        chk("start_while_busy", 64'(busy), 64'(1));
        step();
      end
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done), 64'(1));
    step();
    op_valid = 1'b0;
    chk("idle_after_done", 64'(busy), 64'(0));
    step();
    chk("no_queued_start", 64'(busy), 64'(0));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; op_valid = 1'b0; abort = 1'b0; data_in = '0;
    fork
      monitor();
    join_none
    #1;
    chk("reset_outputs", 64'(outs), 64'(0));
    #11 rst_n = 1'b1;
    step();
    chk("idle_after_reset", 64'(outs), 64'(0));

    abort = 1'b1;
    #1;
    chk("abort_in_idle", 64'(outs), 64'(0));
    step();
    abort = 1'b0;
    chk("abort_in_idle_stays", 64'(busy), 64'(0));

    run_op(16'd3,      16'd5,      0, 1'b1, 1'b0, 32'd15,         41, 4, 10);
    run_op(16'h1234,   16'h0000,   0, 1'b0, 1'b0, 32'd0,          37, 0, 0);
    run_op(16'hFFFF,   16'h0002,   0, 1'b0, 1'b1, 32'hFFFF_FFFE,  39, 2, 2);
    run_op(16'd5,      16'd6,      3, 1'b0, 1'b0, 32'h0000_001E,  42, 2, 2);

    // Abort in SHIFT: no done, clears pulsed, back to IDLE
    start = 1'b1; step(); start = 1'b0; step();
    data_in = 16'd7; op_valid = 1'b1; step();
    data_in = 16'd9; step(); op_valid = 1'b0;
    n = 0;
    while (!shiftA && n < 50) begin step(); n++; end
    chk("shift_decode", 64'(outs), 64'(16'h241A));
    abort = 1'b1;
    #1;
    chk("abort_clears", 64'({clearA, clearQ, clearff, clearCounter}), 64'(4'hF));
    chk("abort_no_done", 64'(done), 64'(0));
    step();
    abort = 1'b0;
    chk("abort_to_idle", 64'(busy), 64'(0));
    step();
    chk("abort_quiet", 64'(outs), 64'(0));

    run_op(16'd7,      16'hFFFD,   0, 1'b0, 1'b0, 32'hFFFF_FFEB,  40, 3, 5);

    // Reset asserted during ARITH
    start = 1'b1; step(); start = 1'b0; step();
    data_in = 16'd3; op_valid = 1'b1; step();
    data_in = 16'd5; step(); op_valid = 1'b0;
    n = 0;
    while (!loadA && n < 50) begin step(); n++; end
    chk("arith_loadA", 64'(loadA), 64'(1));
    chk("arith_subtract", 64'(addSub), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'(outs), 64'(0));
    @(negedge clk);
    chk("reset_hold_outputs", 64'(outs), 64'(0));
    #1 rst_n = 1'b1;
    step();
    chk("post_reset_idle", 64'(outs), 64'(0));

    run_op(16'h7FFF,   16'h8000,   0, 1'b0, 1'b0, 32'hC000_8000,  38, 1, 1);

    step(); step();
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
